decoder_fixed_point: RTL and testbench

Sequential fixed-point dense-layer decoder. It accepts an N_latent-element latent vector z and produces an M_output-element reconstruction: out[j] = b[j] + sum over i of z[i]*w[j*N_latent+i]. Evaluation is time-multiplexed on one multiply-accumulate unit, one MAC per clock, with valid/ready handshakes on both sides. It sits after the encoder stage in the autoencoder datapath and mirrors that stage's vector packing and weight layout.

---
 rtl/decoder_fixed_point.sv | 206 ++++++++++++++++++++
 tb/tb_decoder_fixed_point.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_fixed_point.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_fixed_point
//  Description : Sequential fixed-point dense-layer decoder.
//                out[j] = b[j] + sum_i z[i] * w[j*N_LATENT + i]
//                Time-multiplexed on a single multiply-accumulate unit,
//                one MAC per clock. Valid/ready handshakes on input and output.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   rising-edge clock
//    rst_n      in   asynchronous active-low reset
//    in_valid   in   z is valid
//    in_ready   out  block can accept z (IDLE and not in reset)
//    z          in   latent vector, element i at [(i+1)*BITSIZE-1 : i*BITSIZE]
//    w          in   weights, word j*N_LATENT+i is the term for output j, input i
//    b          in   bias, element j at word j
//    out_valid  out  out holds a complete result
//    out_ready  in   downstream accepts out
//    out        out  result, element j at word j
//    busy       out  high while computing
// ============================================================================
module decoder_fixed_point #(
    parameter int N_LATENT = 4,
    parameter int M_OUTPUT = 9,
    parameter int BITSIZE  = 32,
    parameter int FRAC     = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [N_LATENT*BITSIZE-1:0]          z,
    input  logic [N_LATENT*M_OUTPUT*BITSIZE-1:0] w,
    input  logic [M_OUTPUT*BITSIZE-1:0]          b,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [M_OUTPUT*BITSIZE-1:0]          out,
    output logic                             busy
);

    // ------------------------------------------------------------------------
    // Counter and index widths
    // ------------------------------------------------------------------------
    localparam int c_I_W    = (N_LATENT > 1) ? $clog2(N_LATENT) : 1;
    localparam int c_J_W    = (M_OUTPUT > 1) ? $clog2(M_OUTPUT) : 1;
    localparam int c_WIDX_W = (N_LATENT * M_OUTPUT > 1) ? $clog2(N_LATENT * M_OUTPUT) : 1;

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    logic [N_LATENT*BITSIZE-1:0] r_z;
    logic [BITSIZE-1:0]          r_acc;
    logic [c_I_W-1:0]            r_i;
    logic [c_J_W-1:0]            r_j;
    logic [BITSIZE-1:0]          r_out_arr [M_OUTPUT];

    // ------------------------------------------------------------------------
    // Word views of the packed buses
    // ------------------------------------------------------------------------
    logic [BITSIZE-1:0] w_z_arr [N_LATENT];
    logic [BITSIZE-1:0] w_w_arr [N_LATENT*M_OUTPUT];
    logic [BITSIZE-1:0] w_b_arr [M_OUTPUT];

    genvar gi;
    generate
        for (gi = 0; gi < N_LATENT; gi++) begin : g_z_words
            assign w_z_arr[gi] = r_z[gi*BITSIZE +: BITSIZE];
        end
        for (gi = 0; gi < N_LATENT*M_OUTPUT; gi++) begin : g_w_words
            assign w_w_arr[gi] = w[gi*BITSIZE +: BITSIZE];
        end
        for (gi = 0; gi < M_OUTPUT; gi++) begin : g_b_words
            assign w_b_arr[gi] = b[gi*BITSIZE +: BITSIZE];
            assign out[gi*BITSIZE +: BITSIZE] = r_out_arr[gi];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // MAC datapath
    // ------------------------------------------------------------------------
    logic [c_WIDX_W-1:0]          w_widx;
    logic [BITSIZE-1:0]           w_z_sel;
    logic [BITSIZE-1:0]           w_w_sel;
    logic signed [2*BITSIZE-1:0]  w_prod_full;
    logic [BITSIZE-1:0]           w_prod;
    logic [BITSIZE-1:0]           w_acc_base;
    logic [BITSIZE-1:0]           w_acc_next;
    logic                         w_last_i;
    logic                         w_last_j;

    assign w_widx  = c_WIDX_W'(r_j) * c_WIDX_W'(N_LATENT) + c_WIDX_W'(r_i);
    assign w_z_sel = w_z_arr[r_i];
    assign w_w_sel = w_w_arr[w_widx];

    // Full-precision signed product; the arithmetic shift floors toward minus
    // infinity and the cast keeps bits [FRAC+BITSIZE-1 : FRAC].
    assign w_prod_full = $signed(w_z_sel) * $signed(w_w_sel);
    assign w_prod      = BITSIZE'(w_prod_full >>> FRAC);

    // The first term of each output row seeds the accumulator with its bias.
    assign w_acc_base = (r_i == '0) ? w_b_arr[r_j] : r_acc;
    assign w_acc_next = w_acc_base + w_prod;   // wraps modulo 2^BITSIZE

    assign w_last_i = (r_i == c_I_W'(N_LATENT - 1));
    assign w_last_j = (r_j == c_J_W'(M_OUTPUT - 1));

    // ------------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------------
    // in_ready looks at rst_n directly so it drops the instant reset asserts
    // and rises on release without waiting for an edge.
    assign in_ready  = (r_state == S_IDLE) && rst_n;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_COMPUTE);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_next = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (w_last_i && w_last_j) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers: latch z on accept, run one MAC per COMPUTE cycle.
    // out is only written in COMPUTE, so it is held through DONE and IDLE.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z   <= '0;
            r_acc <= '0;
            r_i   <= '0;
            r_j   <= '0;
            for (int k = 0; k < M_OUTPUT; k++) begin
                r_out_arr[k] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_z <= z;
                        r_i <= '0;
                        r_j <= '0;
                    end
                end
                S_COMPUTE: begin
                    r_acc <= w_acc_next;
                    if (w_last_i) begin
                        r_out_arr[r_j] <= w_acc_next;
                        r_i            <= '0;
                        r_j            <= r_j + 1'b1;
                    end else begin
                        r_i <= r_i + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decoder_fixed_point.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_fixed_point
//  Description : Directed self-checking bench for decoder_fixed_point.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_fixed_point;

    localparam int N  = 4;
    localparam int M  = 9;
    localparam int BW = 32;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [N*BW-1:0]   z;
    logic [N*M*BW-1:0] w;
    logic [M*BW-1:0]   b;
    logic              out_valid;
    logic              out_ready;
    logic [M*BW-1:0]   out;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] zv [N];
    logic [31:0] wv [N*M];
    logic [31:0] bv [M];
    logic [31:0] ev [M];

    decoder_fixed_point #(
        .N_LATENT (N),
        .M_OUTPUT (M),
        .BITSIZE  (BW),
        .FRAC     (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z         (z),
        .w         (w),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] out_word(input int j);
        return out[j*BW +: BW];
    endfunction

    task automatic clear_vecs();
        for (int i = 0; i < N; i++)   zv[i] = 32'h0;
        for (int i = 0; i < N*M; i++) wv[i] = 32'h0;
        for (int i = 0; i < M; i++)   begin bv[i] = 32'h0; ev[i] = 32'h0; end
    endtask

    task automatic load_vecs();
        for (int i = 0; i < N; i++)   z[i*BW +: BW] = zv[i];
        for (int i = 0; i < N*M; i++) w[i*BW +: BW] = wv[i];
        for (int i = 0; i < M; i++)   b[i*BW +: BW] = bv[i];
    endtask

    task automatic set_nominal();
        clear_vecs();
        for (int i = 0; i < N; i++)   zv[i] = 32'h0001_0000;
        for (int i = 0; i < N*M; i++) wv[i] = 32'h0000_8000;
        for (int i = 0; i < M; i++)   begin bv[i] = 32'h0000_4000; ev[i] = 32'h0002_4000; end
        load_vecs();
    endtask

    // Accept a job at the next edge (E0), then count edges until out_valid,
    // tallying busy samples taken after each edge before the result appears.
    task automatic run_job(output int lat, output int bsy);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        bsy = 0;
        while (!out_valid && lat < 200) begin
            if (busy) bsy++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_outs(input string tag);
        for (int j = 0; j < M; j++) begin
            check_eq($sformatf("%s_out%0d", tag, j), out_word(j), ev[j]);
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("release_valid", {31'b0, out_valid}, 32'h0);
        check_eq("release_ready", {31'b0, in_ready}, 32'h1);
        out_ready = 1'b0;
    endtask

    int lat;
    int bsy;

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        z = '0;
        w = '0;
        b = '0;

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        for (int j = 0; j < M; j++) check_eq($sformatf("rst_out%0d", j), out_word(j), 32'h0);
        check_eq("rst_valid", {31'b0, out_valid}, 32'h0);
        check_eq("rst_busy",  {31'b0, busy},      32'h0);
        check_eq("rst_ready", {31'b0, in_ready},  32'h0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check_eq("rel_ready", {31'b0, in_ready}, 32'h1);

        // Nominal job
        set_nominal();
        run_job(lat, bsy);
        check_eq("nom_latency", lat, 32'd36);
        check_eq("nom_busy",    bsy, 32'd36);
        check_outs("nom");
        check_eq("done_ready", {31'b0, in_ready}, 32'h0);

        // Backpressure with in_valid toggling
        for (int k = 0; k < 10; k++) begin
            in_valid = ~in_valid;
            @(posedge clk);
            #1;
            check_eq("bp_valid", {31'b0, out_valid}, 32'h1);
            check_eq("bp_ready", {31'b0, in_ready},  32'h0);
            check_eq("bp_busy",  {31'b0, busy},      32'h0);
            check_eq("bp_out0",  out_word(0), 32'h0002_4000);
            check_eq("bp_out8",  out_word(8), 32'h0002_4000);
        end
        in_valid = 1'b0;
        release_out();
        check_eq("idle_hold_out0", out_word(0), 32'h0002_4000);

        // Sign and indexing
        clear_vecs();
        zv[0] = 32'hFFFE_0000;
        zv[3] = 32'h0001_0000;
        wv[0] = 32'h0001_8000;
        wv[7] = 32'h0001_0000;
        for (int j = 0; j < M; j++) begin bv[j] = j << 16; ev[j] = j << 16; end
        ev[0] = 32'hFFFD_0000;
        ev[1] = 32'h0002_0000;
        load_vecs();
        run_job(lat, bsy);
        check_eq("sign_latency", lat, 32'd36);
        check_outs("sign");
        release_out();

        // Truncation toward minus infinity, out_ready held high in advance
        clear_vecs();
        zv[0] = 32'hFFFF_FFFF;
        wv[0] = 32'h0000_8000;
        ev[0] = 32'hFFFF_FFFF;
        load_vecs();
        out_ready = 1'b1;
        run_job(lat, bsy);
        check_eq("floor_latency", lat, 32'd36);
        check_eq("floor_out0", out_word(0), ev[0]);
        check_eq("floor_out5", out_word(5), 32'h0);
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", {31'b0, out_valid}, 32'h0);

        // Small positive product truncates to zero
        clear_vecs();
        zv[0] = 32'h0000_0001;
        wv[0] = 32'h0000_8000;
        load_vecs();
        run_job(lat, bsy);
        check_eq("trunc_out0", out_word(0), 32'h0);
        @(posedge clk);
        #1;

        // Wrap modulo 2^32
        clear_vecs();
        zv[0] = 32'h7FFF_0000;
        wv[0] = 32'h0002_0000;
        load_vecs();
        run_job(lat, bsy);
        check_eq("wrap_out0", out_word(0), 32'hFFFE_0000);
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset in the middle of a job, at compute edge E10
        clear_vecs();
        zv[0] = 32'hFFFE_0000;
        wv[0] = 32'h0001_8000;
        for (int j = 0; j < M; j++) bv[j] = 32'h0005_0000;
        load_vecs();
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int j = 0; j < M; j++) check_eq($sformatf("mid_rst_out%0d", j), out_word(j), 32'h0);
        check_eq("mid_rst_valid", {31'b0, out_valid}, 32'h0);
        check_eq("mid_rst_ready", {31'b0, in_ready},  32'h0);
        check_eq("mid_rst_busy",  {31'b0, busy},      32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("mid_hold_ready", {31'b0, in_ready},  32'h0);
        check_eq("mid_hold_valid", {31'b0, out_valid}, 32'h0);
        #2 rst_n = 1'b1;
        #1;

        // Fresh nominal job after reset
        set_nominal();
        run_job(lat, bsy);
        check_eq("post_latency", lat, 32'd36);
        check_outs("post");
        release_out();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
